// File: rtl/ivl_uvm_ovl_clk_period_mon.sv
// Measures the period of an asynchronous monitored clock in clk cycles,
// checks it against a tolerance window and reports lock status and errors.
module ivl_uvm_ovl_clk_period_mon #(
  parameter int EXP_PERIOD_CYC = 10,
  parameter int TOL_CYC        = 1,
  parameter int CNT_W          = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_CNT       = 4,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr_err,
  input  logic                 mon_in,
  output logic [CNT_W-1:0]     period_cnt,
  output logic                 period_vld,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 timeout,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int GR_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(2 * EXP_PERIOD_CYC);
  localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(EXP_PERIOD_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(EXP_PERIOD_CYC + TOL_CYC);
  localparam logic [GR_W-1:0]  LOCK_V = GR_W'(LOCK_CNT);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GR_W-1:0]        good_run_q, good_run_d;
  logic                   locked_d;
  logic                   measuring, capture, good, to_hit, err_event;
  logic [ERR_CNT_W-1:0]   err_cnt_d;

  // Synchronizer latency is identical for every edge, so it cancels out of P.
  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  assign measuring = en && (state_q == ST_MEASURE);
  assign capture   = measuring && rise;
  assign good      = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);
  // A rise on the limit cycle is a (bad) measurement, never a timeout.
  assign to_hit    = measuring && !rise && (cnt_q == TO_CNT);
  assign err_event = (capture && !good) || to_hit;

  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARM;
        ST_ARM:     if (rise) state_d = ST_MEASURE;
        ST_MEASURE: if (to_hit) state_d = ST_ARM;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!en || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else if (state_q == ST_ARM) begin
      cnt_d = rise ? CNT_W'(1) : '0;
    end else if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (to_hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    good_run_d = good_run_q;
    locked_d   = locked;
    if (!en || (state_q == ST_IDLE)) begin
      good_run_d = '0;
      locked_d   = 1'b0;
    end else if (capture && good) begin
      if (good_run_q < LOCK_V) good_run_d = good_run_q + GR_W'(1);
      if (good_run_d == LOCK_V) locked_d = 1'b1;
    end else if (err_event) begin
      good_run_d = '0;
      locked_d   = 1'b0;
    end
  end

  // Counts the visible err_pulse; a clear coinciding with a pulse keeps that one.
  always_comb begin
    err_cnt_d = err_cnt;
    if (clr_err) begin
      err_cnt_d = err_pulse ? ERR_CNT_W'(1) : '0;
    end else if (err_pulse && (err_cnt != '1)) begin
      err_cnt_d = err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      s_d        <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      good_run_q <= '0;
      locked     <= 1'b0;
      period_cnt <= '0;
      period_vld <= 1'b0;
      err_pulse  <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], mon_in};
      s_d        <= s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_run_q <= good_run_d;
      locked     <= locked_d;
      period_vld <= capture;
      err_pulse  <= err_event;
      timeout    <= to_hit;
      err_cnt    <= err_cnt_d;
      if (capture) period_cnt <= cnt_q;
    end
  end

endmodule

// File: tb/tb_ivl_uvm_ovl_clk_period_mon.sv
// Directed bench for ivl_uvm_ovl_clk_period_mon: mon_in is driven on clk negedges
// so rise-to-rise spacing in clk cycles is exactly the expected measured period.
`timescale 1ns/1ps
module tb_ivl_uvm_ovl_clk_period_mon;

  logic        clk = 1'b0;
  logic        rst_n, en, clr_err, mon_in;
  logic [15:0] period_cnt, period_cnt2;
  logic        period_vld, locked, err_pulse, timeout;
  logic        period_vld2, locked2, err_pulse2, timeout2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;
  logic [1:0]  dbg_state, dbg_state2;

  int n_checks = 0;
  int n_pass   = 0;

  // monitor log, written only by the monitor process
  int vld_n = 0, err_n = 0, to_n = 0, unlock_n = 0, lock_vld = -1;
  logic lk_prev = 1'b0;
  logic [15:0] got_q[$];

  // scoreboard, main process only
  logic [15:0] exp_q[$];
  int rd_idx = 0;
  int b_vld, b_err, b_to, b_unl, wait_n;

  // clock / reset block
  always #0.5 clk = ~clk;

  ivl_uvm_ovl_clk_period_mon dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err), .mon_in(mon_in),
    .period_cnt(period_cnt), .period_vld(period_vld), .locked(locked),
    .err_pulse(err_pulse), .timeout(timeout), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  ivl_uvm_ovl_clk_period_mon #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err), .mon_in(mon_in),
    .period_cnt(period_cnt2), .period_vld(period_vld2), .locked(locked2),
    .err_pulse(err_pulse2), .timeout(timeout2), .err_cnt(err_cnt2),
    .dbg_state(dbg_state2)
  );

  always @(negedge clk) begin
    if (period_vld) begin
      vld_n++;
      got_q.push_back(period_cnt);
    end
    if (err_pulse) err_n++;
    if (timeout) to_n++;
    if (locked && !lk_prev) lock_vld = vld_n;
    if (!locked && lk_prev) unlock_n++;
    lk_prev = locked;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic sb_drain(input string tag);
    logic [15:0] exp_v;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      if (rd_idx < got_q.size()) check_eq(tag, int'(got_q[rd_idx]), int'(exp_v));
      else check_eq({tag, "_missing"}, -1, int'(exp_v));
      rd_idx++;
    end
    check_eq({tag, "_count"}, got_q.size(), rd_idx);
  endtask

  // driver: one mon_in period of p clk cycles, starting with the rising edge
  task automatic mon_period(input int p);
    mon_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    mon_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic snap();
    b_vld = vld_n;
    b_err = err_n;
    b_to  = to_n;
    b_unl = unlock_n;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_err = 1'b0; mon_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_period_cnt", int'(period_cnt), 0);
    check_eq("rst_period_vld", int'(period_vld), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_err_pulse", int'(err_pulse), 0);
    check_eq("rst_timeout", int'(timeout), 0);
    check_eq("rst_err_cnt", int'(err_cnt), 0);
    check_eq("rst_state", int'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("arm_state", int'(dbg_state), 1);

    // 1: steady period 10, first rise only arms
    snap();
    for (int i = 0; i < 7; i++) mon_period(10);
    for (int i = 0; i < 6; i++) exp_q.push_back(16'd10);
    sb_drain("t1_period");
    check_eq("t1_lock_at_vld", lock_vld - b_vld, 4);
    check_eq("t1_locked", int'(locked), 1);
    check_eq("t1_err_pulses", err_n - b_err, 0);
    check_eq("t1_err_cnt", int'(err_cnt), 0);
    check_eq("t1_state", int'(dbg_state), 2);

    // 2: one 12-cycle period breaks lock, four good periods relock
    snap();
    mon_period(12);
    for (int i = 0; i < 5; i++) mon_period(10);
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd12);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'd10);
    sb_drain("t2_period");
    check_eq("t2_err_pulses", err_n - b_err, 1);
    check_eq("t2_unlocks", unlock_n - b_unl, 1);
    check_eq("t2_relock_at_vld", lock_vld - b_vld, 6);
    check_eq("t2_locked", int'(locked), 1);
    check_eq("t2_err_cnt", int'(err_cnt), 1);

    // 3: disable -> IDLE with err_cnt held, then alternating 9/11 locks
    snap();
    en = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t3_idle_state", int'(dbg_state), 0);
    check_eq("t3_idle_locked", int'(locked), 0);
    check_eq("t3_idle_err_cnt", int'(err_cnt), 1);
    check_eq("t3_idle_no_vld", vld_n - b_vld, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    mon_period(9); mon_period(11); mon_period(9); mon_period(11); mon_period(9);
    exp_q.push_back(16'd9); exp_q.push_back(16'd11);
    exp_q.push_back(16'd9); exp_q.push_back(16'd11);
    sb_drain("t3_period");
    check_eq("t3_err_pulses", err_n - b_err, 0);
    check_eq("t3_lock_at_vld", lock_vld - b_vld, 4);
    check_eq("t3_locked", int'(locked), 1);

    // 4: mon_in stuck low; last rise driven 9 cycles before the wait starts
    snap();
    wait_n = 0;
    while (!timeout && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq("t4_timeout_latency", wait_n, 14);
    check_eq("t4_err_with_timeout", int'(err_pulse), 1);
    check_eq("t4_state_arm", int'(dbg_state), 1);
    check_eq("t4_locked", int'(locked), 0);
    check_eq("t4_period_hold", int'(period_cnt), 11);
    @(negedge clk);
    check_eq("t4_timeout_width", int'(timeout), 0);
    check_eq("t4_err_cnt", int'(err_cnt), 2);
    check_eq("t4_timeouts", to_n - b_to, 1);
    check_eq("t4_no_vld", vld_n - b_vld, 0);

    // 5: async reset in the middle of MEASURE, during a period_vld pulse
    for (int i = 0; i < 5; i++) mon_period(10);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'd10);
    mon_in = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(16'd10);
    check_eq("t5_pre_vld", int'(period_vld), 1);
    check_eq("t5_pre_locked", int'(locked), 1);
    check_eq("t5_pre_err_cnt", int'(err_cnt), 2);
    #0.2 rst_n = 1'b0;
    #0.1;
    check_eq("t5_rst_vld", int'(period_vld), 0);
    check_eq("t5_rst_period_cnt", int'(period_cnt), 0);
    check_eq("t5_rst_locked", int'(locked), 0);
    check_eq("t5_rst_err_cnt", int'(err_cnt), 0);
    check_eq("t5_rst_state", int'(dbg_state), 0);
    sb_drain("t5_period");
    mon_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 6: five bad periods; 2-bit counter saturates at 3
    snap();
    for (int i = 0; i < 6; i++) mon_period(14);
    for (int i = 0; i < 5; i++) exp_q.push_back(16'd14);
    sb_drain("t6_period");
    check_eq("t6_err_pulses", err_n - b_err, 5);
    check_eq("t6_err_cnt", int'(err_cnt), 5);
    check_eq("t6_err_cnt_sat", int'(err_cnt2), 3);
    check_eq("t6_locked", int'(locked), 0);

    // 7: rise exactly at the timeout limit is a measurement of 20, not a timeout
    snap();
    mon_period(20);
    mon_period(14);
    exp_q.push_back(16'd14);
    exp_q.push_back(16'd20);
    sb_drain("t7_period");
    check_eq("t7_timeouts", to_n - b_to, 0);
    check_eq("t7_err_pulses", err_n - b_err, 2);
    check_eq("t7_period_cnt", int'(period_cnt), 20);
    check_eq("t7_err_cnt", int'(err_cnt), 7);
    check_eq("t7_err_cnt_sat", int'(err_cnt2), 3);

    // clr_err in the same cycle as an err_pulse leaves a count of 1
    mon_in = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(16'd14);
    check_eq("clr_pre_err_pulse", int'(err_pulse), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("clr_same_cycle", int'(err_cnt), 1);
    check_eq("clr_same_cycle_w2", int'(err_cnt2), 1);
    check_eq("clr_err_width", int'(err_pulse), 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("clr_alone", int'(err_cnt), 0);
    repeat (3) @(negedge clk);
    mon_in = 1'b0;
    repeat (7) @(negedge clk);
    sb_drain("clr_period");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
